// File: rtl/weight_store_if.sv
// Bus bundle for the synapse weight store: read port, random write,
// streaming bulk load and status.
interface weight_store_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              R_en;
  logic [ADDR_W-1:0] R_Addr;
  logic [DATA_W-1:0] R_Data;
  logic              R_valid;
  logic              W_en;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              L_start;
  logic              L_valid;
  logic [DATA_W-1:0] L_Data;
  logic              L_ready;
  logic              L_done;
  logic              Busy;

  modport master (
    output R_en, R_Addr, W_en, W_Addr, W_Data,
    output L_start, L_valid, L_Data,
    input  R_Data, R_valid, L_ready, L_done, Busy
  );

  modport slave (
    input  R_en, R_Addr, W_en, W_Addr, W_Data,
    input  L_start, L_valid, L_Data,
    output R_Data, R_valid, L_ready, L_done, Busy
  );
endinterface

// File: rtl/weight_store.sv
// Synapse weight memory: registered read, random write, bulk load
// with auto-incrementing pointer, optional sweep-clear after reset.
// Ports: Clk, Rst (sync, active-high), bus (weight_store_if.slave).
module weight_store #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic           Clk,
  input logic           Rst,
  weight_store_if.slave bus
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } state_t;

  localparam state_t RST_STATE =
    CLEAR_ON_RST ? CLEAR : IDLE;
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              l_done_q, l_done_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_hit;
  logic              wr_hit;

  assign rd_hit = {1'b0, bus.R_Addr} < DEPTH_C;
  assign wr_hit = {1'b0, bus.W_Addr} < DEPTH_C;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d  = ld_ptr_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    l_done_d  = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;

    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr_q;
        if (clr_ptr_q == LAST) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.L_start) begin
          state_d  = LOAD;
          ld_ptr_d = '0;
        end
        if (bus.W_en && wr_hit) begin
          we    = 1'b1;
          waddr = bus.W_Addr;
          wdata = bus.W_Data;
        end
      end
      LOAD: begin
        // A restart wins over a beat arriving in the same cycle.
        if (bus.L_start) begin
          ld_ptr_d = '0;
        end else if (bus.L_valid) begin
          we    = 1'b1;
          waddr = ld_ptr_q;
          wdata = bus.L_Data;
          if (ld_ptr_q == LAST) begin
            state_d  = IDLE;
            ld_ptr_d = '0;
            l_done_d = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Read sees memory before this cycle's write (read-first).
    if (state_q != CLEAR && bus.R_en) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_hit ? mem[bus.R_Addr] : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
      ld_ptr_q  <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      l_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      l_done_q  <= l_done_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (we && !Rst) begin
      mem[waddr] <= wdata;
    end
  end

  assign bus.R_Data  = r_data_q;
  assign bus.R_valid = r_valid_q;
  assign bus.L_ready = (state_q == LOAD);
  assign bus.L_done  = l_done_q;
  assign bus.Busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_weight_store.sv
// Directed bench for weight_store: a 256-entry instance and a
// 200-entry instance sharing one clock.
module tb_weight_store;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  weight_store_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  weight_store_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  weight_store #(
    .DATA_W(8), .DEPTH(256), .ADDR_W(8), .CLEAR_ON_RST(1'b1)
  ) u_a (
    .Clk(clk), .Rst(rst_a), .bus(ifa.slave)
  );

  weight_store #(
    .DATA_W(8), .DEPTH(200), .ADDR_W(8), .CLEAR_ON_RST(1'b1)
  ) u_b (
    .Clk(clk), .Rst(rst_b), .bus(ifb.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.R_en = 0; ifa.R_Addr = 0;
    ifa.W_en = 0; ifa.W_Addr = 0; ifa.W_Data = 0;
    ifa.L_start = 0; ifa.L_valid = 0; ifa.L_Data = 0;
  endtask

  task automatic idle_b();
    ifb.R_en = 0; ifb.R_Addr = 0;
    ifb.W_en = 0; ifb.W_Addr = 0; ifb.W_Data = 0;
    ifb.L_start = 0; ifb.L_valid = 0; ifb.L_Data = 0;
  endtask

  task automatic write_a(input logic [7:0] a, input logic [7:0] d);
    ifa.W_en = 1; ifa.W_Addr = a; ifa.W_Data = d;
    step();
    ifa.W_en = 0;
  endtask

  // Clear sweep on A: counts Busy cycles after Rst drops.
  task automatic clear_sweep_a(input string tag);
    int n;
    int rv;
    n = 0; rv = 0;
    rst_a = 0;
    while (ifa.Busy === 1'b1 && n < 1000) begin
      ifa.R_en = 1; ifa.R_Addr = 8'd3;
      ifa.W_en = (n == 5); ifa.W_Addr = 0; ifa.W_Data = 8'h99;
      ifa.L_start = (n == 7);
      step();
      n++;
      if (ifa.R_valid === 1'b1 && ifa.Busy === 1'b1) rv++;
    end
    idle_a();
    total_cnt++;
    if (n !== 256)
      $display("FAIL %s_busy_len got %0d want 256", tag, n);
    else pass_cnt++;
    total_cnt++;
    if (rv !== 0)
      $display("FAIL %s_rvalid_in_clear got %0d want 0", tag, rv);
    else pass_cnt++;
    total_cnt++;
    if (ifa.L_ready !== 1'b0)
      $display("FAIL %s_no_load got %b want 0", tag, ifa.L_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255;
    idle_a(); idle_b();
    rst_a = 1;
    step(); step();
    total_cnt++;
    if (ifa.R_valid !== 0 || ifa.R_Data !== 0 || ifa.L_ready !== 0
        || ifa.L_done !== 0 || ifa.Busy !== 1)
      $display("FAIL reset_state got rv=%b rd=%h lr=%b ld=%b bz=%b want 0 00 0 0 1",
               ifa.R_valid, ifa.R_Data, ifa.L_ready, ifa.L_done, ifa.Busy);
    else pass_cnt++;
    clear_sweep_a("clr");
    for (int i = 0; i < 3; i++) begin
      ifa.R_en = 1; ifa.R_Addr = addrs[i];
      step();
      ifa.R_en = 0;
      total_cnt++;
      if (ifa.R_valid !== 1 || ifa.R_Data !== 8'h00)
        $display("FAIL clr_read%0d got rv=%b d=%h want 1 00",
                 addrs[i], ifa.R_valid, ifa.R_Data);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ifa.R_valid !== 0)
        $display("FAIL clr_rvalid_drop got %b want 0", ifa.R_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_rw();
    logic [7:0] ra [3];
    logic [7:0] rd [3];
    ra[0] = 3; ra[1] = 250; ra[2] = 3;
    rd[0] = 8'hA5; rd[1] = 8'h5A; rd[2] = 8'hA5;
    write_a(8'd3, 8'hA5);
    write_a(8'd250, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      ifa.R_en = 1; ifa.R_Addr = ra[i];
      step();
      total_cnt++;
      if (ifa.R_valid !== 1 || ifa.R_Data !== rd[i])
        $display("FAIL b2b_read%0d got rv=%b d=%h want 1 %h",
                 i, ifa.R_valid, ifa.R_Data, rd[i]);
      else pass_cnt++;
    end
    ifa.R_en = 0;
    step();
    total_cnt++;
    if (ifa.R_valid !== 0 || ifa.R_Data !== 8'hA5)
      $display("FAIL read_hold got rv=%b d=%h want 0 a5",
               ifa.R_valid, ifa.R_Data);
    else pass_cnt++;
  endtask

  task automatic test_bulk_load();
    int beats, cyc, pulses, errs;
    logic v, acc;
    logic [7:0] exp;
    ifa.L_start = 1;
    step();
    ifa.L_start = 0;
    total_cnt++;
    if (ifa.L_ready !== 1)
      $display("FAIL load_ready got %b want 1", ifa.L_ready);
    else pass_cnt++;
    beats = 0; cyc = 0; pulses = 0;
    while (beats < 256 && cyc < 5000) begin
      v = 1'($urandom_range(0, 1));
      ifa.L_valid = v;
      ifa.L_Data = beats[7:0] ^ 8'hFF;
      ifa.W_en = (beats == 100);
      ifa.W_Addr = 8'd5; ifa.W_Data = 8'h00;
      acc = v && ifa.L_ready;
      step();
      cyc++;
      if (acc) beats++;
      if (ifa.L_done === 1'b1) pulses++;
    end
    idle_a();
    total_cnt++;
    if (beats !== 256)
      $display("FAIL load_beats got %0d want 256", beats);
    else pass_cnt++;
    total_cnt++;
    if (ifa.L_done !== 1 || pulses !== 1)
      $display("FAIL load_done got ld=%b pulses=%0d want 1 1",
               ifa.L_done, pulses);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ifa.L_done !== 0 || ifa.L_ready !== 0)
      $display("FAIL load_end got ld=%b lr=%b want 0 0",
               ifa.L_done, ifa.L_ready);
    else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      ifa.R_en = 1; ifa.R_Addr = 8'(i);
      exp = 8'(i) ^ 8'hFF;
      step();
      total_cnt++;
      if (ifa.R_valid !== 1 || ifa.R_Data !== exp) begin
        errs++;
        if (errs < 8)
          $display("FAIL load_rb%0d got %h want %h", i, ifa.R_Data, exp);
      end else pass_cnt++;
    end
    ifa.R_en = 0;
    step();
  endtask

  task automatic test_read_during_write();
    write_a(8'd7, 8'h11);
    ifa.W_en = 1; ifa.W_Addr = 7; ifa.W_Data = 8'h22;
    ifa.R_en = 1; ifa.R_Addr = 7;
    step();
    ifa.W_en = 0;
    total_cnt++;
    if (ifa.R_Data !== 8'h11)
      $display("FAIL rdw_old got %h want 11", ifa.R_Data);
    else pass_cnt++;
    step();
    ifa.R_en = 0;
    total_cnt++;
    if (ifa.R_Data !== 8'h22)
      $display("FAIL rdw_new got %h want 22", ifa.R_Data);
    else pass_cnt++;
  endtask

  task automatic test_restart_reset();
    logic [7:0] ra [3];
    logic [7:0] rd [3];
    ra[0] = 0; ra[1] = 1; ra[2] = 10;
    rd[0] = 8'h77; rd[1] = 8'h41; rd[2] = 8'hF5;
    ifa.L_start = 1;
    step();
    ifa.L_start = 0;
    for (int i = 0; i < 10; i++) begin
      ifa.L_valid = 1; ifa.L_Data = 8'h40 + 8'(i);
      step();
    end
    ifa.L_start = 1; ifa.L_Data = 8'hEE;
    step();
    ifa.L_start = 0; ifa.L_Data = 8'h77;
    step();
    ifa.L_valid = 0;
    for (int i = 0; i < 3; i++) begin
      ifa.R_en = 1; ifa.R_Addr = ra[i];
      step();
      total_cnt++;
      if (ifa.R_Data !== rd[i])
        $display("FAIL restart_rd%0d got %h want %h",
                 ra[i], ifa.R_Data, rd[i]);
      else pass_cnt++;
    end
    ifa.R_en = 0;
    ifa.L_valid = 1; ifa.L_Data = 8'h55;
    rst_a = 1;
    step();
    total_cnt++;
    if (ifa.L_ready !== 0 || ifa.Busy !== 1)
      $display("FAIL midload_rst got lr=%b bz=%b want 0 1",
               ifa.L_ready, ifa.Busy);
    else pass_cnt++;
    idle_a();
    clear_sweep_a("reclr");
    for (int i = 0; i < 3; i++) begin
      ifa.R_en = 1; ifa.R_Addr = ra[i];
      step();
      total_cnt++;
      if (ifa.R_Data !== 8'h00)
        $display("FAIL reclr_rd%0d got %h want 00", ra[i], ifa.R_Data);
      else pass_cnt++;
    end
    ifa.R_en = 0;
    step();
  endtask

  task automatic test_small_depth();
    int n, beats;
    logic [7:0] ra [4];
    logic [7:0] rd [4];
    ra[0] = 220; ra[1] = 199; ra[2] = 20; ra[3] = 92;
    rd[0] = 0; rd[1] = 8'h44; rd[2] = 0; rd[3] = 0;
    idle_b();
    step();
    rst_b = 0;
    n = 0;
    while (ifb.Busy === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 200)
      $display("FAIL d200_busy_len got %0d want 200", n);
    else pass_cnt++;
    ifb.W_en = 1; ifb.W_Addr = 220; ifb.W_Data = 8'h33;
    step();
    ifb.W_Addr = 199; ifb.W_Data = 8'h44;
    step();
    ifb.W_en = 0;
    for (int i = 0; i < 4; i++) begin
      ifb.R_en = 1; ifb.R_Addr = ra[i];
      step();
      total_cnt++;
      if (ifb.R_valid !== 1 || ifb.R_Data !== rd[i])
        $display("FAIL d200_rd%0d got rv=%b d=%h want 1 %h",
                 ra[i], ifb.R_valid, ifb.R_Data, rd[i]);
      else pass_cnt++;
    end
    ifb.R_en = 0;
    ifb.L_start = 1;
    step();
    ifb.L_start = 0;
    beats = 0; n = 0;
    while (ifb.L_ready === 1'b1 && n < 1000) begin
      ifb.L_valid = 1; ifb.L_Data = 8'(beats) + 8'h01;
      step();
      beats++; n++;
    end
    ifb.L_valid = 0;
    total_cnt++;
    if (beats !== 200 || ifb.L_done !== 1)
      $display("FAIL d200_load got beats=%0d ld=%b want 200 1",
               beats, ifb.L_done);
    else pass_cnt++;
    ifb.R_en = 1; ifb.R_Addr = 199;
    step();
    ifb.R_en = 0;
    total_cnt++;
    if (ifb.R_Data !== 8'hC8)
      $display("FAIL d200_last got %h want c8", ifb.R_Data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_random_rw();
    test_bulk_load();
    test_read_during_write();
    test_restart_reset();
    test_small_depth();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
